sensor_freq_counter: RTL and testbench

Front-end stage that feeds the colour sensor decision logic. Takes the two asynchronous square-wave outputs of the light-to-frequency sensors (`sensorFreq`, `sensorFreq2`) and synchronises them to `clk`. Counts rising edges of each over a fixed gate window and presents both counts with a one-cycle valid strobe. The downstream colour classifier compares these counts instead of raw pin levels.

---
 rtl/sensor_pkg.sv | 11 +
 rtl/sync_edge_detect.sv | 26 ++
 rtl/sensor_freq_counter.sv | 115 +++++++++++
 tb/tb_sensor_freq_counter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_pkg.sv
// Shared constants and channel index type for the colour-sensor front end.
package sensor_pkg;
    localparam int DEF_CNT_W       = 20;
    localparam int DEF_GATE_CYCLES = 1000000;
    localparam int NUM_CH          = 2;

    typedef enum logic {
        CH1 = 1'b0,
        CH2 = 1'b1
    } sensor_ch_e;
endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser plus history flop; rise is a one-cycle pulse on each
// synchronised 0->1 transition.
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);
    logic meta_reg;
    logic sync_reg;
    logic hist_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
            hist_reg <= 1'b0;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            hist_reg <= sync_reg;
        end
    end

    assign rise = sync_reg & ~hist_reg;
endmodule

// File: rtl/sensor_freq_counter.sv
// Counts rising edges of two asynchronous sensor outputs over a free-running
// gate window. Optional ch1_gt_ch2 comparator enabled by FREQ_CMP_EN.
import sensor_pkg::*;

module sensor_freq_counter #(
    parameter int GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensorFreq,
    input  logic             sensorFreq2,
    output logic [CNT_W-1:0] count1,
    output logic [CNT_W-1:0] count2,
    output logic             ovf1,
    output logic             ovf2,
`ifdef FREQ_CMP_EN
    output logic             ch1_gt_ch2,
`endif
    output logic             valid
);
    localparam int GATE_W = $clog2(GATE_CYCLES);

    logic [GATE_W-1:0] gate_reg;
    logic              close;
    logic [NUM_CH-1:0] pin_vec;
    logic [NUM_CH-1:0] rise;
    logic [CNT_W-1:0]  cnt_next [NUM_CH];
    logic [NUM_CH-1:0] ovf_next;

    logic [CNT_W-1:0]  count1_reg;
    logic [CNT_W-1:0]  count2_reg;
    logic              ovf1_reg;
    logic              ovf2_reg;
    logic              valid_reg;

    assign pin_vec[CH1] = sensorFreq;
    assign pin_vec[CH2] = sensorFreq2;
    assign close = (gate_reg == GATE_W'(GATE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || close) begin
            gate_reg <= '0;
        end else begin
            gate_reg <= gate_reg + GATE_W'(1);
        end
    end

    // cnt_next/ovf_next already include this cycle's edge, so the window-close
    // load sees it while the accumulator itself restarts from zero.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [CNT_W-1:0] acc_reg;
        logic             sticky_reg;
        logic             full;

        sync_edge_detect u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (pin_vec[gi]),
            .rise (rise[gi])
        );

        assign full         = &acc_reg;
        assign cnt_next[gi] = acc_reg + CNT_W'(rise[gi] & ~full);
        assign ovf_next[gi] = sticky_reg | (rise[gi] & full);

        always_ff @(posedge clk) begin
            if (rst || close) begin
                acc_reg    <= '0;
                sticky_reg <= 1'b0;
            end else begin
                acc_reg    <= cnt_next[gi];
                sticky_reg <= ovf_next[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count1_reg <= '0;
            count2_reg <= '0;
            ovf1_reg   <= 1'b0;
            ovf2_reg   <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= close;
            if (close) begin
                count1_reg <= cnt_next[CH1];
                count2_reg <= cnt_next[CH2];
                ovf1_reg   <= ovf_next[CH1];
                ovf2_reg   <= ovf_next[CH2];
            end
        end
    end

`ifdef FREQ_CMP_EN
    logic gt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            gt_reg <= 1'b0;
        end else if (close) begin
            gt_reg <= (cnt_next[CH1] > cnt_next[CH2]);
        end
    end

    assign ch1_gt_ch2 = gt_reg;
`endif

    assign count1 = count1_reg;
    assign count2 = count2_reg;
    assign ovf1   = ovf1_reg;
    assign ovf2   = ovf2_reg;
    assign valid  = valid_reg;
endmodule

// File: tb/tb_sensor_freq_counter.sv
// Randomised bench for sensor_freq_counter: a pin-history model predicts each
// window's counts; a monitor compares them whenever valid strobes.
module tb_sensor_freq_counter;
    localparam int G    = 200;
    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;

    typedef struct {
        int cyc;
        int c1;
        int c2;
        bit o1;
        bit o2;
        bit gt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sensorFreq = 1'b0;
    logic         sensorFreq2 = 1'b0;
    logic [W-1:0] count1;
    logic [W-1:0] count2;
    logic         ovf1;
    logic         ovf2;
    logic         valid;
`ifdef FREQ_CMP_EN
    logic         ch1_gt_ch2;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cur_cycle = 0;
    bit   mon_en = 1'b0;
    bit   chk_reset = 1'b0;
    bit   done = 1'b0;
    bit   done_checked = 1'b0;
    bit   pin_q1[$];
    bit   pin_q2[$];
    exp_t sb[$];
    exp_t mon_e;

    sensor_freq_counter #(.GATE_CYCLES(G), .CNT_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sensorFreq (sensorFreq),
        .sensorFreq2(sensorFreq2),
        .count1     (count1),
        .count2     (count2),
        .ovf1       (ovf1),
        .ovf2       (ovf2),
`ifdef FREQ_CMP_EN
        .ch1_gt_ch2 (ch1_gt_ch2),
`endif
        .valid      (valid)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cur_cycle);
        end
    endtask

    // A pin rise sampled in cycle r is detected in cycle r+2; count those
    // detections falling inside window w. Pins before cycle 0 read as 0.
    function automatic int count_rises(input int ch, input int w);
        int n = 0;
        for (int r = w * G - 2; r <= w * G + G - 3; r++) begin
            bit cur;
            bit prev;
            if (r < 0) continue;
            cur  = (ch == 1) ? pin_q1[r] : pin_q2[r];
            prev = (r == 0) ? 1'b0 : ((ch == 1) ? pin_q1[r-1] : pin_q2[r-1]);
            if (cur && !prev) n++;
        end
        return n;
    endfunction

    function automatic int pick_hold();
        int r = $urandom_range(0, 9);
        if (r == 0) return $urandom_range(150, 300);
        if (r < 4) return 2;
        return $urandom_range(2, 14);
    endfunction

    task automatic run_segment(input int ncyc, input bit steady);
        int rem1 = 0;
        int rem2 = 0;
        bit l1 = 1'b0;
        bit l2 = 1'b0;
        pin_q1.delete();
        pin_q2.delete();
        for (int c = 0; c < ncyc; c++) begin
            bit fixed = steady && (c < 3 * G);
            if (rem1 == 0) begin
                l1 = ~l1;
                rem1 = fixed ? 10 : pick_hold();
            end
            if (rem2 == 0) begin
                l2 = ~l2;
                rem2 = fixed ? 20 : pick_hold();
            end
            rem1--;
            rem2--;
            rst = 1'b0;
            mon_en = 1'b1;
            cur_cycle = c;
            sensorFreq = l1;
            sensorFreq2 = l2;
            pin_q1.push_back(l1);
            pin_q2.push_back(l2);
            if (c % G == G - 1) begin
                exp_t e;
                int n1 = count_rises(1, c / G);
                int n2 = count_rises(2, c / G);
                e.cyc = c + 1;
                e.c1  = (n1 > MAXC) ? MAXC : n1;
                e.c2  = (n2 > MAXC) ? MAXC : n2;
                e.o1  = (n1 > MAXC);
                e.o2  = (n2 > MAXC);
                e.gt  = (e.c1 > e.c2);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_reset) begin
            chk("reset_count1", count1, 0);
            chk("reset_count2", count2, 0);
            chk("reset_ovf1", ovf1, 0);
            chk("reset_ovf2", ovf2, 0);
            chk("reset_valid", valid, 0);
`ifdef FREQ_CMP_EN
            chk("reset_gt", ch1_gt_ch2, 0);
`endif
        end
        if (mon_en) begin
            if (sb.size() > 0 && cur_cycle > sb[0].cyc) begin
                checks++;
                errors++;
                $display("FAIL valid_timeout actual=none expected=valid at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=1 expected=0 (cycle %0d)", cur_cycle);
                end else begin
                    mon_e = sb.pop_front();
                    chk("valid_cycle", cur_cycle, mon_e.cyc);
                    chk("count1", count1, mon_e.c1);
                    chk("count2", count2, mon_e.c2);
                    chk("ovf1", ovf1, 32'(mon_e.o1));
                    chk("ovf2", ovf2, 32'(mon_e.o2));
`ifdef FREQ_CMP_EN
                    chk("ch1_gt_ch2", ch1_gt_ch2, 32'(mon_e.gt));
`endif
                    $display("window end cycle %0d: count1=%0d ovf1=%0d count2=%0d ovf2=%0d",
                             cur_cycle, count1, ovf1, count2, ovf2);
                end
            end else if (cur_cycle == G - 1) begin
                chk("pre_strobe_count1", count1, 0);
                chk("pre_strobe_count2", count2, 0);
                chk("pre_strobe_ovf", {ovf1, ovf2}, 0);
            end
        end
        if (done && !done_checked) begin
            done_checked = 1'b1;
            chk("scoreboard_drained", sb.size(), 0);
        end
    end

    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        run_segment(15 * G + 100, 1'b1);
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        chk_reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset = 1'b0;
        @(posedge clk);
        #1;
        run_segment(10 * G + 3, 1'b0);
        mon_en = 1'b0;
        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
